mem_access_stage: RTL and testbench

- Pipeline MEM stage. Sits between the EX/MEM stage register and the MEM/WB stage register.
- Performs loads and stores against a variable-latency data memory using a req/ack handshake. Handles byte, halfword and word sizes with lane alignment and sign/zero extension.
- Stalls the pipeline while an access is outstanding. Hands RegWrite, Mem2Reg, Mem, ALU and WriteReg results to the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/load_align.sv | 30 +++
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg : shared encodings for the MEM stage (access sizes, FSM states)
// Revision     : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // The unused size code 2'b11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// load_align : selects the addressed lane of a read word and extends it
// Revision   : 1.0
// ============================================================================
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] byte_lane;
    logic [31:0] half_lane;

    always_comb begin
        byte_lane = rdata >> {addr, 3'b000};
        half_lane = rdata >> {addr[1], 4'b0000};
        case (norm_size(size))
            SZ_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane[7:0]};
            SZ_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane[15:0]};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : pipeline MEM stage with req/ack data-memory handshake,
//                    lane alignment, pipeline stall and access timeout
// Revision         : 1.0
// ============================================================================
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic        RegWrite_in,
    input  logic        Mem2Reg_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] StoreData_in,
    input  logic [4:0]  WriteReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic        RegWrite_out,
    output logic        Mem2Reg_out,
    output logic [31:0] Mem_out,
    output logic [31:0] ALU_out,
    output logic [4:0]  WriteReg_out
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             signed_q;
    logic [31:0]      rdata_q;
    logic [31:0]      load_val;
    logic [1:0]       size_eff;
    logic             mem_op;
    logic             misaligned;
    logic             start;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;

    always_comb begin
        size_eff   = norm_size(MemSize_in);
        mem_op     = valid_in && (MemRead_in || MemWrite_in);
        misaligned = mem_op && (((size_eff == SZ_HALF) && ALU_in[0]) ||
                                ((size_eff == SZ_WORD) && (ALU_in[1:0] != 2'b00)));
        start      = (state == ST_IDLE) && mem_op && !misaligned;
        cnt_next   = cnt + 1'b1;
        case (size_eff)
            SZ_BYTE: begin
                be_calc    = 4'b0001 << ALU_in[1:0];
                wdata_calc = {4{StoreData_in[7:0]}};
            end
            SZ_HALF: begin
                be_calc    = ALU_in[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{StoreData_in[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = StoreData_in;
            end
        endcase
    end

    load_align u_load_align (
        .rdata    (rdata_q),
        .addr     (addr_lo_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .result   (load_val)
    );

    // WB controls reach MEM/WB only in a non-stalled cycle; elsewhere RegWrite is held off.
    always_comb begin
        ALU_out      = ALU_in;
        WriteReg_out = WriteReg_in;
        Mem2Reg_out  = Mem2Reg_in;
        stall_out    = start || (state == ST_BUSY);
        misalign_out = (state == ST_IDLE) && misaligned;
        Mem_out      = '0;
        RegWrite_out = RegWrite_in;
        case (state)
            ST_IDLE: if (mem_op) RegWrite_out = 1'b0;
            ST_BUSY: RegWrite_out = 1'b0;
            ST_HOLD: begin
                RegWrite_out = RegWrite_in && !bus_err_out;
                if (!dmem_we) Mem_out = load_val;
            end
            default: RegWrite_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            size_q      <= SZ_BYTE;
            addr_lo_q   <= 2'b00;
            signed_q    <= 1'b0;
            rdata_q     <= '0;
            bus_err_out <= 1'b0;
        end else begin
            bus_err_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_in;
                        dmem_addr  <= {ALU_in[31:2], 2'b00};
                        dmem_be    <= be_calc;
                        dmem_wdata <= wdata_calc;
                        size_q     <= size_eff;
                        addr_lo_q  <= ALU_in[1:0];
                        signed_q   <= MemSigned_in;
                        cnt        <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack landing on the timeout cycle still completes normally.
                    if (dmem_ack) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= ST_HOLD;
                    end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                        rdata_q     <= '0;
                        dmem_req    <= 1'b0;
                        bus_err_out <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_HOLD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage : randomized scoreboard bench for mem_access_stage
// Revision            : 1.0
// ============================================================================
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, MemRead_in, MemWrite_in, MemSigned_in, RegWrite_in, Mem2Reg_in;
    logic [1:0]  MemSize_in;
    logic [31:0] ALU_in, StoreData_in;
    logic [4:0]  WriteReg_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_out, misalign_out, bus_err_out, RegWrite_out, Mem2Reg_out;
    logic [31:0] Mem_out, ALU_out;
    logic [4:0]  WriteReg_out;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .MemSize_in(MemSize_in), .MemSigned_in(MemSigned_in),
        .RegWrite_in(RegWrite_in), .Mem2Reg_in(Mem2Reg_in), .ALU_in(ALU_in),
        .StoreData_in(StoreData_in), .WriteReg_in(WriteReg_in), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_out(stall_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out), .RegWrite_out(RegWrite_out),
        .Mem2Reg_out(Mem2Reg_out), .Mem_out(Mem_out), .ALU_out(ALU_out), .WriteReg_out(WriteReg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wreg;
        logic        regw;
        logic        m2r;
        logic        mis;
        logic        err;
        int          stall;
    } cmp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        int          delay;
        int          cycles;
    } req_t;

    cmp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem  [16];
    logic [31:0] phys_mem [16];
    int          checks = 0;
    int          errors = 0;
    bit          sb_en = 1'b0;
    logic        force_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: per-instruction results derived from the stage's architectural rules.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input bit rw, input bit m2r, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] wreg, input int d);
        cmp_t        e;
        req_t        r;
        int          esz, o, idx;
        bit          tout;
        logic [31:0] word, v, mask;
        esz = (sz == 2'b11) ? 2 : int'(sz);
        o   = int'(alu[1:0]);
        idx = int'(alu[5:2]);
        e.alu = alu; e.wreg = wreg; e.m2r = m2r; e.mem = 32'h0;
        e.mis = 1'b0; e.err = 1'b0; e.stall = 0; e.regw = rw;
        if (rd || wr) begin
            if ((esz == 1 && (o % 2) != 0) || (esz == 2 && o != 0)) begin
                e.mis  = 1'b1;
                e.regw = 1'b0;
            end else begin
                tout     = (d >= TO);
                e.err    = tout;
                e.stall  = tout ? TO + 1 : d + 2;
                e.regw   = rw && !tout;
                r.addr   = alu & 32'hFFFF_FFFC;
                r.we     = wr;
                r.delay  = d;
                r.cycles = tout ? TO : d + 1;
                mask     = (esz == 0) ? 32'hFF : (esz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
                r.be     = (esz == 0) ? 4'(1 << o) : (esz == 1) ? 4'(3 << o) : 4'hF;
                r.wdata  = (esz == 0) ? (sd & 32'hFF) * 32'h0101_0101 :
                           (esz == 1) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
                word = ref_mem[idx];
                if (wr) begin
                    if (!tout)
                        ref_mem[idx] = (word & ~(mask << (8 * o))) | ((sd & mask) << (8 * o));
                end else if (!tout) begin
                    v = (word >> (8 * o)) & mask;
                    if (sg && esz == 0 && v >= 32'h80)   v = v - 32'h100;
                    if (sg && esz == 1 && v >= 32'h8000) v = v - 32'h1_0000;
                    e.mem = v;
                end
                req_q.push_back(r);
            end
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_in = 1'b1; MemRead_in = rd; MemWrite_in = wr; MemSize_in = sz;
        MemSigned_in = sg; RegWrite_in = rw; Mem2Reg_in = m2r; ALU_in = alu;
        StoreData_in = sd; WriteReg_in = wreg;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_out) return;
        end
        chk("stall_release_timeout", 32'h1, 32'h0);
    endtask

    // Monitor: one pop per instruction, at the cycle MEM/WB would capture it.
    initial begin
        cmp_t e;
        int   stall_cnt = 0;
        bit   bad_phase = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en && rst && valid_in) begin
                if (stall_out) begin
                    stall_cnt++;
                    if (bus_err_out || misalign_out || RegWrite_out) bad_phase = 1'b1;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("RegWrite_out", 32'(RegWrite_out), 32'(e.regw));
                    chk("Mem_out", Mem_out, e.mem);
                    chk("ALU_out", ALU_out, e.alu);
                    chk("WriteReg_out", 32'(WriteReg_out), 32'(e.wreg));
                    chk("Mem2Reg_out", 32'(Mem2Reg_out), 32'(e.m2r));
                    chk("misalign_out", 32'(misalign_out), 32'(e.mis));
                    chk("bus_err_out", 32'(bus_err_out), 32'(e.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    chk("stall_phase_outputs_quiet", 32'(bad_phase), 32'h0);
                    stall_cnt = 0;
                    bad_phase = 1'b0;
                end
            end
        end
    end

    // Memory responder: its own storage, written only through dmem_be/dmem_wdata.
    initial begin
        req_t        r;
        int          k = 0;
        bit          active = 1'b0;
        bit          unstable = 1'b0;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        int          idx;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                dmem_ack   = force_ack;
                dmem_rdata = 32'hFFFF_FFFF;
                active     = 1'b0;
            end else if (dmem_req) begin
                if (!active) begin
                    active = 1'b1; k = 0; unstable = 1'b0;
                    a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
                    if (req_q.size() == 0) begin
                        chk("unexpected_dmem_req", 32'h1, 32'h0);
                        r.delay = 1000; r.cycles = -1;
                    end else begin
                        r = req_q.pop_front();
                        chk("dmem_addr", dmem_addr, r.addr);
                        chk("dmem_we", 32'(dmem_we), 32'(r.we));
                        chk("dmem_be", 32'(dmem_be), 32'(r.be));
                        if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
                    end
                end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_be !== b0 || dmem_we !== we0) begin
                    unstable = 1'b1;
                end
                k++;
                idx = int'(dmem_addr[5:2]);
                if (k - 1 == r.delay) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_be[b]) phys_mem[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
                        dmem_rdata = $urandom;
                    end else begin
                        dmem_rdata = phys_mem[idx];
                    end
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                end
            end else begin
                if (active) begin
                    chk("dmem_req_cycles", 32'(k), 32'(r.cycles));
                    chk("dmem_req_stable", 32'(unstable), 32'h0);
                    active = 1'b0;
                end
                dmem_ack = 1'b0;
            end
        end
    end

    initial begin
        logic [1:0] sz;
        bit         rd, wr;
        int         d;
        rst = 1'b0;
        valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemSize_in = 2'b00;
        MemSigned_in = 1'b0; RegWrite_in = 1'b0; Mem2Reg_in = 1'b0; ALU_in = 32'h0;
        StoreData_in = 32'h0; WriteReg_in = 5'd0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_dmem_we", 32'(dmem_we), 32'h0);
        chk("reset_dmem_be", 32'(dmem_be), 32'h0);
        chk("reset_dmem_addr", dmem_addr, 32'h0);
        chk("reset_dmem_wdata", dmem_wdata, 32'h0);
        chk("reset_bus_err", 32'(bus_err_out), 32'h0);
        chk("reset_stall", 32'(stall_out), 32'h0);
        chk("reset_Mem_out", Mem_out, 32'h0);
        rst   = 1'b1;
        sb_en = 1'b1;

        ref_mem[0]  = 32'h80FF_FF7F;
        phys_mem[0] = 32'h80FF_FF7F;
        issue(1, 0, 2'b00, 1, 1, 1, 32'h0000_1003, 32'h0, 5'd3, 1);
        issue(0, 1, 2'b01, 0, 0, 0, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0);
        issue(1, 0, 2'b01, 0, 1, 1, 32'h0000_0001, 32'h0, 5'd4, 0);
        issue(1, 0, 2'b10, 0, 1, 1, 32'h0000_1008, 32'h0, 5'd5, 10);
        issue(0, 0, 2'b10, 0, 1, 0, 32'hDEAD_BEEF, 32'h0, 5'd6, 0);
        issue(1, 0, 2'b10, 0, 1, 1, 32'h0000_100C, 32'h0, 5'd7, TO - 1);
        issue(1, 1, 2'b11, 0, 0, 0, 32'h0000_1010, 32'hCAFE_F00D, 5'd8, 2);
        issue(1, 0, 2'b00, 0, 1, 1, 32'h0000_1003, 32'h0, 5'd9, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                valid_in = 1'b0;
                @(negedge clk);
            end
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'h0000_3000 | 32'($urandom_range(0, 63)),
                  $urandom, 5'($urandom_range(0, 31)), d);
        end
        chk("queues_drained", 32'(exp_q.size() + req_q.size()), 32'h0);

        sb_en = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; MemSize_in = 2'b10;
        ALU_in = 32'h0000_1010; RegWrite_in = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_req", 32'(dmem_req), 32'h1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("rst_async_req_drop", 32'(dmem_req), 32'h0);
        chk("rst_async_be", 32'(dmem_be), 32'h0);
        valid_in = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("late_ack_req", 32'(dmem_req), 32'h0);
        chk("late_ack_stall", 32'(stall_out), 32'h0);
        chk("late_ack_Mem_out", Mem_out, 32'h0);
        chk("late_ack_bus_err", 32'(bus_err_out), 32'h0);
        chk("late_ack_RegWrite", 32'(RegWrite_out), 32'h1);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
